// File: rtl/pbus_pkg.sv
// Shared types and widths for the P bus responder: FSM states, bus widths, fallback byte.
// Pure declarations; no timing or backpressure of its own.
package pbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam int CROM_AW = 24;
  localparam int SROM_AW = 17;
  localparam int PBUS_DW = 8;

  localparam logic [PBUS_DW-1:0] LATE_BYTE_DEFAULT = 8'hFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pck_edge.sv
// Registered rising-edge detector for one latch pin; rise is combinational from pin vs last sample.
// Zero latency from pin to rise; no backpressure.
module pck_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= pin;
  end

  assign rise = pin & ~prev;

endmodule

// File: rtl/pbus_responder.sv
// P bus responder: latches C-ROM address on PCK1, fetches one S/L0 ROM byte on PCK2 and drives it on PBUS[23:16].
// PCK edge to outputs 1 cycle, ACK to drive 1 cycle; ROM stalls bounded by DEADLINE. Optional PBUS_LATE_CNT_EN adds LATE_CNT.
module pbus_responder
  import pbus_pkg::*;
#(
  parameter int                 DEADLINE  = 8,
  parameter logic [PBUS_DW-1:0] LATE_BYTE = LATE_BYTE_DEFAULT
) (
  input  logic               CLK_24M,
  input  logic               RESET,
  input  logic [CROM_AW-1:0] PBUS_IN,
  input  logic               PCK1,
  input  logic               PCK2,
  input  logic               S2H1,
  input  logic               nVCS,
  output logic [CROM_AW-1:0] CROM_ADDR,
  output logic               CROM_VALID,
  output logic [SROM_AW-1:0] SROM_ADDR,
  output logic               SROM_SEL_L0,
  output logic               SROM_REQ,
  input  logic               SROM_ACK,
  input  logic [PBUS_DW-1:0] SROM_DATA,
  output logic [PBUS_DW-1:0] PBUS_DOUT,
  output logic               PBUS_OE
`ifdef PBUS_LATE_CNT_EN
  , output logic [15:0]      LATE_CNT
`endif
);

  localparam logic [3:0] DL_LAST = 4'(DEADLINE - 1);

  logic               pck1_edge;
  logic               pck2_edge;
  state_t             state, state_nxt;
  logic [3:0]         age, age_nxt;
  logic [PBUS_DW-1:0] dout_nxt;
  logic [15:0]        saddr_hi;
  logic               late_evt;
  logic               timeout;

  pck_edge u_pck1 (.clk(CLK_24M), .rst(RESET), .pin(PCK1), .rise(pck1_edge));
  pck_edge u_pck2 (.clk(CLK_24M), .rst(RESET), .pin(PCK2), .rise(pck2_edge));

  assign timeout = (age == DL_LAST);

  // A new PCK2 always wins: it aborts any fetch in flight and restarts the deadline.
  always_comb begin
    state_nxt = state;
    age_nxt   = age;
    dout_nxt  = PBUS_DOUT;
    late_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (pck2_edge) begin
          state_nxt = REQ;
          age_nxt   = 4'd0;
        end
      end
      REQ: begin
        if (pck2_edge) begin
          age_nxt  = 4'd0;
          late_evt = 1'b1;
        end else if (timeout) begin
          state_nxt = DRIVE;
          dout_nxt  = LATE_BYTE;
          late_evt  = 1'b1;
        end else if (SROM_ACK) begin
          state_nxt = DRIVE;
          dout_nxt  = SROM_DATA;
        end else begin
          age_nxt = age + 4'd1;
        end
      end
      DRIVE: begin
        if (pck2_edge) begin
          state_nxt = REQ;
          age_nxt   = 4'd0;
        end else if (pck1_edge) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state       <= IDLE;
      age         <= 4'd0;
      PBUS_DOUT   <= '0;
      CROM_ADDR   <= '0;
      CROM_VALID  <= 1'b0;
      saddr_hi    <= 16'd0;
      SROM_SEL_L0 <= 1'b0;
    end else begin
      state      <= state_nxt;
      age        <= age_nxt;
      PBUS_DOUT  <= dout_nxt;
      CROM_VALID <= pck1_edge;
      if (pck1_edge) CROM_ADDR <= PBUS_IN;
      if (pck2_edge) begin
        saddr_hi    <= PBUS_IN[15:0];
        SROM_SEL_L0 <= ~nVCS;
      end
    end
  end

`ifdef PBUS_LATE_CNT_EN
  always_ff @(posedge CLK_24M) begin
    if (RESET)         LATE_CNT <= 16'd0;
    else if (late_evt) LATE_CNT <= sat_inc16(LATE_CNT);
  end
`else
  logic unused_late;
  assign unused_late = late_evt;
`endif

  assign SROM_ADDR = {saddr_hi, S2H1};
  assign SROM_REQ  = (state == REQ);
  assign PBUS_OE   = (state == DRIVE);

endmodule

// File: tb/tb_pbus_responder.sv
// Bench for pbus_responder: directed cycle table, hand-written corner sequence, then random traffic vs a reference model.
module tb_pbus_responder;

  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        rst, p1, p2, nvcs, s2h1, ack;
  logic [7:0]  data;
  logic [23:0] pbus;
  logic [23:0] crom_addr;
  logic        crom_valid;
  logic [16:0] srom_addr;
  logic        srom_sel_l0, srom_req, pbus_oe;
  logic [7:0]  pbus_dout;
`ifdef PBUS_LATE_CNT_EN
  logic [15:0] late_cnt;
`endif

  always #5 clk = ~clk;

  pbus_responder #(.DEADLINE(DL), .LATE_BYTE(8'hFF)) dut (
    .CLK_24M(clk), .RESET(rst), .PBUS_IN(pbus), .PCK1(p1), .PCK2(p2),
    .S2H1(s2h1), .nVCS(nvcs), .CROM_ADDR(crom_addr), .CROM_VALID(crom_valid),
    .SROM_ADDR(srom_addr), .SROM_SEL_L0(srom_sel_l0), .SROM_REQ(srom_req),
    .SROM_ACK(ack), .SROM_DATA(data), .PBUS_DOUT(pbus_dout), .PBUS_OE(pbus_oe)
`ifdef PBUS_LATE_CNT_EN
    , .LATE_CNT(late_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: a fetch is "pending" for a number of elapsed cycles, or the bus is "driving".
  logic        m_prev1 = 0, m_prev2 = 0, m_pend = 0, m_drv = 0, m_cv = 0, m_sel = 0;
  int          m_age = 0, m_late = 0;
  logic [7:0]  m_dout = 0;
  logic [23:0] m_crom = 0;
  logic [15:0] m_shi = 0;

  task automatic model_tick();
    logic e1, e2;
    e1 = p1 && !m_prev1;
    e2 = p2 && !m_prev2;
    if (rst) begin
      m_prev1 = 0; m_prev2 = 0; m_pend = 0; m_drv = 0; m_cv = 0; m_sel = 0;
      m_age = 0; m_late = 0; m_dout = 0; m_crom = 0; m_shi = 0;
      return;
    end
    m_prev1 = p1;
    m_prev2 = p2;
    m_cv = e1;
    if (e1) m_crom = pbus;
    if (e2) begin
      if (m_pend && m_late < 65535) m_late++;
      m_pend = 1; m_age = 0; m_drv = 0;
      m_shi = pbus[15:0];
      m_sel = !nvcs;
    end else if (m_pend) begin
      if (m_age == DL - 1) begin
        m_pend = 0; m_drv = 1; m_dout = 8'hFF;
        if (m_late < 65535) m_late++;
      end else if (ack) begin
        m_pend = 0; m_drv = 1; m_dout = data;
      end else begin
        m_age++;
      end
    end else if (m_drv && e1) begin
      m_drv = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_tick();
    chk("m_srom_req",  32'(srom_req),    32'(m_pend));
    chk("m_pbus_oe",   32'(pbus_oe),     32'(m_drv));
    chk("m_pbus_dout", 32'(pbus_dout),   32'(m_dout));
    chk("m_crom_vld",  32'(crom_valid),  32'(m_cv));
    chk("m_crom_addr", 32'(crom_addr),   32'(m_crom));
    chk("m_srom_addr", 32'(srom_addr),   32'({m_shi, s2h1}));
    chk("m_srom_sel",  32'(srom_sel_l0), 32'(m_sel));
`ifdef PBUS_LATE_CNT_EN
    chk("m_late_cnt",  32'(late_cnt),    32'(m_late));
`endif
  endtask

  typedef struct {
    logic        rst, p1, p2, nvcs, s2h1, ack;
    logic [7:0]  data;
    logic [23:0] pbus;
    logic        e_req, e_oe;
    logic [7:0]  e_dout;
    logic        e_cv;
    logic [23:0] e_crom;
    logic [16:0] e_saddr;
    logic        e_sel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic a1, input logic a2, input logic nv, input logic s2,
                     input logic ak, input logic [7:0] d, input logic [23:0] pb,
                     input logic rq, input logic oe, input logic [7:0] dout, input logic cv,
                     input logic [23:0] crom, input logic [16:0] sa, input logic sel);
    vec_t v;
    v.rst = r; v.p1 = a1; v.p2 = a2; v.nvcs = nv; v.s2h1 = s2; v.ack = ak; v.data = d; v.pbus = pb;
    v.e_req = rq; v.e_oe = oe; v.e_dout = dout; v.e_cv = cv; v.e_crom = crom; v.e_saddr = sa; v.e_sel = sel;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1; p1 = 0; p2 = 0; nvcs = 1; s2h1 = 0; ack = 0; data = 0; pbus = 0;

    //  rst p1 p2 nv s2 ak data   pbus          req oe dout   cv crom        saddr      sel
    add(1, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  0, 0, 8'h00, 0, 24'h000000, 17'h00000, 0);
    add(0, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  0, 0, 8'h00, 0, 24'h000000, 17'h00000, 0);
    add(0, 1, 0, 1, 0, 0, 8'h00, 24'hA5C3F0,  0, 0, 8'h00, 1, 24'hA5C3F0, 17'h00000, 0);
    add(0, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  0, 0, 8'h00, 0, 24'hA5C3F0, 17'h00000, 0);
    add(0, 0, 1, 1, 1, 0, 8'h00, 24'h001234,  1, 0, 8'h00, 0, 24'hA5C3F0, 17'h02469, 0);
    add(0, 0, 0, 1, 1, 0, 8'h00, 24'h000000,  1, 0, 8'h00, 0, 24'hA5C3F0, 17'h02469, 0);
    add(0, 0, 0, 1, 1, 1, 8'h5A, 24'h000000,  0, 1, 8'h5A, 0, 24'hA5C3F0, 17'h02469, 0);
    add(0, 0, 0, 1, 1, 0, 8'h00, 24'h000000,  0, 1, 8'h5A, 0, 24'hA5C3F0, 17'h02469, 0);
    add(0, 1, 0, 1, 1, 0, 8'h00, 24'h000777,  0, 0, 8'h5A, 1, 24'h000777, 17'h02469, 0);
    add(0, 0, 0, 1, 1, 1, 8'h33, 24'h000000,  0, 0, 8'h5A, 0, 24'h000777, 17'h02469, 0);
    add(0, 0, 0, 1, 1, 0, 8'h00, 24'h000000,  0, 0, 8'h5A, 0, 24'h000777, 17'h02469, 0);
    add(0, 0, 1, 0, 0, 0, 8'h00, 24'h00ABCD,  1, 0, 8'h5A, 0, 24'h000777, 17'h1579A, 1);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 0, 0, 0, 8'h00, 24'h000000, 1, 0, 8'h5A, 0, 24'h000777, 17'h1579A, 1);
    add(0, 0, 0, 0, 0, 0, 8'h00, 24'h000000,  0, 1, 8'hFF, 0, 24'h000777, 17'h1579A, 1);
    add(0, 0, 0, 0, 0, 0, 8'h00, 24'h000000,  0, 1, 8'hFF, 0, 24'h000777, 17'h1579A, 1);
    add(0, 0, 1, 1, 0, 0, 8'h00, 24'h000001,  1, 0, 8'hFF, 0, 24'h000777, 17'h00002, 0);
    add(0, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  1, 0, 8'hFF, 0, 24'h000777, 17'h00002, 0);
    add(0, 0, 1, 1, 0, 0, 8'h00, 24'h000BEE,  1, 0, 8'hFF, 0, 24'h000777, 17'h017DC, 0);
    for (int k = 0; k < 6; k++)
      add(0, 0, 0, 1, 0, 0, 8'h00, 24'h000000, 1, 0, 8'hFF, 0, 24'h000777, 17'h017DC, 0);
    add(0, 0, 0, 1, 0, 1, 8'hC7, 24'h000000,  0, 1, 8'hC7, 0, 24'h000777, 17'h017DC, 0);
    add(1, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  0, 0, 8'h00, 0, 24'h000000, 17'h00000, 0);
    add(0, 0, 0, 1, 0, 0, 8'h00, 24'h000000,  0, 0, 8'h00, 0, 24'h000000, 17'h00000, 0);
    add(0, 0, 1, 1, 1, 0, 8'h00, 24'h00FACE,  1, 0, 8'h00, 0, 24'h000000, 17'h1F59D, 0);
    add(0, 0, 0, 1, 1, 1, 8'h96, 24'h000000,  0, 1, 8'h96, 0, 24'h000000, 17'h1F59D, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; p1 = tbl[i].p1; p2 = tbl[i].p2; nvcs = tbl[i].nvcs;
      s2h1 = tbl[i].s2h1; ack = tbl[i].ack; data = tbl[i].data; pbus = tbl[i].pbus;
      step();
      chk($sformatf("t%0d_req", i),   32'(srom_req),    32'(tbl[i].e_req));
      chk($sformatf("t%0d_oe", i),    32'(pbus_oe),     32'(tbl[i].e_oe));
      chk($sformatf("t%0d_dout", i),  32'(pbus_dout),   32'(tbl[i].e_dout));
      chk($sformatf("t%0d_cv", i),    32'(crom_valid),  32'(tbl[i].e_cv));
      chk($sformatf("t%0d_crom", i),  32'(crom_addr),   32'(tbl[i].e_crom));
      chk($sformatf("t%0d_saddr", i), 32'(srom_addr),   32'(tbl[i].e_saddr));
      chk($sformatf("t%0d_sel", i),   32'(srom_sel_l0), 32'(tbl[i].e_sel));
`ifdef PBUS_LATE_CNT_EN
      if (i == 20) chk("late_after_timeout", 32'(late_cnt), 32'd1);
      if (i == 23) chk("late_after_abort",   32'(late_cnt), 32'd2);
      if (i == 31) chk("late_after_reset",   32'(late_cnt), 32'd0);
`endif
    end

    // PCK1 and PCK2 together, then an ACK landing on the deadline cycle loses to the timeout.
    ack = 0; p1 = 1; p2 = 1; nvcs = 1; s2h1 = 0; pbus = 24'h12C0DE;
    step();
    chk("both_crom",  32'(crom_addr),  32'h0012C0DE);
    chk("both_cv",    32'(crom_valid), 32'd1);
    chk("both_req",   32'(srom_req),   32'd1);
    chk("both_saddr", 32'(srom_addr),  32'h000181BC);
    p1 = 0; p2 = 0; pbus = 0;
    for (int k = 0; k < DL - 1; k++) step();
    chk("dl_last_req", 32'(srom_req), 32'd1);
    ack = 1; data = 8'h11;
    step();
    chk("dl_ack_oe",   32'(pbus_oe),   32'd1);
    chk("dl_ack_dout", 32'(pbus_dout), 32'h000000FF);
    ack = 0;

    for (int k = 0; k < 4000; k++) begin
      rst  = ($urandom_range(0, 299) == 0);
      p1   = ($urandom_range(0, 9) == 0);
      p2   = ($urandom_range(0, 13) == 0);
      ack  = ($urandom_range(0, 4) == 0);
      nvcs = 1'($urandom);
      s2h1 = 1'($urandom);
      data = 8'($urandom);
      pbus = 24'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
